// File: rtl/mult8_seq_controller_pkg.sv
// Shared constants for the sequenced ALU operations.
// State encodings and operand/iteration sizes used by the multiply path.
package mult8_seq_controller_pkg;

    localparam int MUL_WIDTH = 8;
    localparam int MUL_ITER  = 8;
    localparam int MUL_CNT_W = $clog2(MUL_ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/mult8_seq_controller_csa8b.sv
// csa8b: 8-bit carry-select adder, two nibbles, upper nibble precomputed
// for both carries. Ports: a_i, b_i, cin_i -> sum_o, cout_o.
module mult8_seq_controller_csa8b (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
);

    logic [4:0] lo_s;
    logic [4:0] hi_s0;
    logic [4:0] hi_s1;

    always_comb begin
        lo_s  = {1'b0, a_i[3:0]} + {1'b0, b_i[3:0]} + {4'b0, cin_i};
        hi_s0 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]};
        hi_s1 = {1'b0, a_i[7:4]} + {1'b0, b_i[7:4]} + 5'd1;
    end

    // Low-nibble carry picks the precomputed upper half.
    assign sum_o  = lo_s[4] ? {hi_s1[3:0], lo_s[3:0]}
                            : {hi_s0[3:0], lo_s[3:0]};
    assign cout_o = lo_s[4] ? hi_s1[4] : hi_s0[4];

endmodule

// File: rtl/mult8_seq_controller.sv
// Sequential 8x8 unsigned shift-and-add multiplier on one shared csa8b.
// Ports: clk, rst, in, store_A, store_B, start -> product, busy, done.
module mult8_seq_controller
    import mult8_seq_controller_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,
    parameter int ITER  = MUL_ITER
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in,
    input  logic               store_A,
    input  logic               store_B,
    input  logic               start,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(ITER);

    mul_state_e     state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic             cout;

    assign addend = lo_q[0] ? m_q : '0;

    mult8_seq_controller_csa8b u_add (
        .a_i    (hi_q),
        .b_i    (addend),
        .cin_i  (1'b0),
        .sum_o  (sum),
        .cout_o (cout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // m_q snapshots A so a same-cycle store_A
                    // only affects the next operation.
                    hi_d    = '0;
                    lo_d    = b_q;
                    m_d     = a_q;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Carry-out becomes the top bit of the shift.
                {hi_d, lo_d} = {cout, sum, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != RUN) begin
            if (store_A) a_d = in;
            if (store_B) b_d = in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

    assign product = {hi_q, lo_q};
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_mult8_seq_controller.sv
// Self-checking bench for mult8_seq_controller.
// Cycle-level reference model plus directed literal checks.
module tb_mult8_seq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_bus;
    logic        store_A;
    logic        store_B;
    logic        start;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult8_seq_controller dut (
        .clk     (clk),
        .rst     (rst),
        .in      (in_bus),
        .store_A (store_A),
        .store_B (store_B),
        .start   (start),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Reference model: phase 0 idle, 1..8 iterating, 9 result cycle.
    int mA, mB, m_op, m_res, m_phase;
    logic mon_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mA = 0; mB = 0; m_res = 0; m_phase = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_op    = mA * mB;
                m_phase = 1;
            end
            if (store_A) mA = in_bus;
            if (store_B) mB = in_bus;
        end else if (m_phase <= 8) begin
            if (m_phase == 8) begin
                m_phase = 9;
                m_res   = m_op;
            end else begin
                m_phase++;
            end
        end else begin
            if (store_A) mA = in_bus;
            if (store_B) mB = in_bus;
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("model_busy", busy, (m_phase >= 1 && m_phase <= 8));
            chk("model_done", done, (m_phase == 9));
            if (m_phase == 0 || m_phase == 9)
                chk("model_product", product, m_res);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic load(input int a, input int b);
        in_bus = 8'(a); store_A = 1'b1; tick(); store_A = 1'b0;
        in_bus = 8'(b); store_B = 1'b1; tick(); store_B = 1'b0;
    endtask

    // Pulse start, wait for done, check latency and result.
    task automatic run_op(input string name, input int exp);
        int n;
        start = 1'b1; tick(); start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            tick(); n++;
        end
        chk({name, "_latency"}, n, 9);
        chk({name, "_product"}, product, exp);
        tick();
        chk({name, "_done_drop"}, done, 0);
    endtask

    initial begin
        int n, p1, p2, dcnt;
        rst = 1'b1; in_bus = '0; store_A = 0; store_B = 0; start = 0;
        tick(); tick();
        rst = 1'b0;
        mon_en = 1'b1;
        chk("reset_product", product, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);

        load(13, 11);
        run_op("m13x11", 16'h008F);
        load(255, 255);
        run_op("m255x255", 16'hFE01);
        load(0, 200);
        run_op("m0x200", 0);
        load(77, 0);
        run_op("m77x0", 0);

        // Mid-run strobes are ignored.
        load(6, 7);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        in_bus = 8'd99; start = 1; store_A = 1; store_B = 1;
        tick();
        start = 0; store_A = 0; store_B = 0;
        n = 4;
        while (!done && n < 20) begin tick(); n++; end
        chk("ignore_latency", n, 9);
        chk("ignore_product", product, 42);
        tick(); tick();
        run_op("m6x7_again", 42);

        // Same-cycle store and start: start uses old operands.
        in_bus = 8'd5; store_A = 1'b1;
        run_op("store_with_start", 42);
        run_op("after_store", 35);

        // Reset at iteration 4 aborts.
        load(50, 3);
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_product", product, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dcnt++;
            tick();
        end
        chk("abort_no_done", dcnt, 0);
        load(50, 3);
        run_op("m50x3", 150);

        // Held start: back-to-back ops.
        load(2, 3);
        start = 1'b1;
        p1 = -1; p2 = -1; n = 0;
        while (p2 < 0 && n < 40) begin
            tick(); n++;
            if (done) begin
                chk("held_product", product, 6);
                if (p1 < 0) p1 = n;
                else p2 = n;
            end
        end
        start = 1'b0;
        chk("held_spacing", p2 - p1, 10);
        chk("held_first", p1, 9);
        for (int i = 0; i < 12; i++) tick();
        chk("final_idle_busy", busy, 0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mult8_seq_controller.md
Name: mult8_seq_controller

Overview:
- Sequential 8x8 unsigned shift-and-add multiplier that time-shares one csa8b 8-bit adder over 8 iterations.
- Operands are latched from the shared 8-bit `in` bus by store_A/store_B strobes.
- `start` launches a multiply; `product` is a 16-bit result, qualified by a one-cycle `done` pulse.
- Sits beside the adder controllers in the ALU as the multiply path.

Parameters:
- WIDTH, 8, operand width; must equal the csa8b adder width (only legal value 8).
- ITER, 8, number of add/shift iterations; must equal WIDTH.

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  reset, synchronous, active-high
- in  input  8  shared operand bus
- store_A  input  1  load `in` into multiplicand register A
- store_B  input  1  load `in` into multiplier register B
- start  input  1  request multiply of current A*B
- product  output  16  result {hi,lo}
- busy  output  1  multiply in progress
- done  output  1  one-cycle result-valid pulse

Behaviour:
- Reset (rst=1 at a clk edge): A=0, B=0, hi=0, lo=0, count=0, state=IDLE, busy=0, done=0, product=0. Reset overrides every other input.
- Reset mid-operation aborts the run. No done pulse follows.
- States:
  - IDLE: start=1 -> LOAD_RUN entry: hi<=0, lo<=B, count<=0, busy<=1, state<=RUN.
  - RUN: one iteration per clock. Adder inputs are (hi, lo[0] ? A : 0) with cin=0, giving {cout,sum}. Then {hi,lo} <= {cout,sum,lo[7:1]}, and count<=count+1. When count==ITER-1 on this edge, state<=DONE, busy<=0, done<=1.
  - DONE: lasts exactly one cycle. done<=0, state<=IDLE.
- Latency: start sampled at edge E0. Iterations occur at E1..E8. done=1 and product valid during the cycle after E8. done returns to 0 after E9.
- product = {hi,lo} continuously. It holds the last result until the next start is accepted. During RUN it shows intermediate values and is not valid.
- start is ignored in RUN and DONE. It is not queued. A start held high through DONE is accepted in IDLE at E9+1.
- store_A/store_B:
  - Honoured in IDLE and DONE only; ignored while busy=1, so A cannot change mid-multiply.
  - Loading B after start does not affect the running multiply, because lo captured B at E0.
  - Both strobes asserted together load the same `in` value into both registers.
  - A store_* in the same IDLE cycle as start: start uses the pre-edge A/B values; the store takes effect for the next operation.
- Arithmetic:
  - Unsigned only. The adder carry-out is the shifted-in bit, so no overflow is possible; max 255*255 = 0xFE01 fits in 16 bits.
  - Any cin input of the adder is tied 0.
- Multiplier zero still runs all 8 iterations. There is no early termination, so latency is fixed.

Decomposition:
- Shared constants file holds the state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the width/iteration constants for reuse by other sequenced ALU ops.
- One sub-module: the existing csa8b adder, instantiated once as the datapath.
- The controller holds only the FSM, A/B/hi/lo/count registers, and the operand mux.

Test Plan:
- Reset, then store_A with in=13, store_B with in=11, start -> busy=1 for 8 cycles, done pulse 9 edges after start, product=16'h008F (143).
- A=255, B=255, start -> product=16'hFE01; checks carry-out shift-in.
- A=0, B=200 and A=77, B=0 -> product=0 in both cases, with the same 9-edge latency and a single done pulse each.
- Start A=6, B=7. Mid-run, pulse start, store_A with in=99, and store_B with in=99 -> ignored. product=42, and a following start computes 6*7 again.
- Start A=50, B=3 and assert rst at iteration 4 -> next cycle all outputs 0, state IDLE, no done pulse. A subsequent load/start of 50*3 gives 150.
- start held high continuously with A=2, B=3 -> back-to-back ops with done pulses spaced 10 cycles apart, product=6 each time.
